// File: rtl/sram_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_arbiter_if
// Purpose  : Bundles the requester handshakes, SRAM control strobes and
//            status signals of the SRAM access arbiter.
// Ports    : slave  - arbiter side (takes requests, drives acks/strobes)
//            master - requester/bench side
//            wr_req/wr_addr/wr_data/wr_ack : write requester handshake
//            rd_req/rd_addr/rd_data/rd_ack : read requester handshake
//            sram_*                         : SRAM address, strobes, DQ enable
//            busy/state_num                 : FSM status for the display
// Revision : 1.0 - initial release
// ============================================================================
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ack;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we_n;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_lb_n;
  logic              sram_ub_n;
  logic              sram_dq_oe;
  logic              busy;
  logic [2:0]        state_num;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ack, rd_data, rd_ack, sram_addr, sram_we_n, sram_ce_n,
           sram_oe_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy, state_num
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ack, rd_data, rd_ack, sram_addr, sram_we_n, sram_ce_n,
           sram_oe_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy, state_num
  );
endinterface
`default_nettype wire

// File: rtl/sram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_arbiter
// Purpose  : Shares one async 16-bit SRAM between a write requester and a
//            read requester with req/ack handshakes and round-robin ties.
//            Generates all SRAM strobes and the DQ tri-state control.
// Ports    : clk     - audio clock, rising edge
//            rst     - synchronous reset, active-high
//            bus     - handshake/strobe/status interface (slave side)
//            sram_dq - bidirectional SRAM data bus
// Revision : 1.0 - initial release
// ============================================================================
module sram_access_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int ACCESS_CYC = 2      // legal range 1..15
) (
  input  wire logic              clk,
  input  wire logic              rst,
  sram_access_arbiter_if.slave   bus,
  inout  wire logic [DATA_W-1:0] sram_dq
);

  localparam logic [3:0] C_LAST_CNT = 4'(ACCESS_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR_ACC = 2'd1,
    S_RD_ACC = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_last_rd;     // 1 = most recent grant went to the reader
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_wr_ack;
  logic              r_rd_ack;
  logic              r_we_n;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_byte_n;      // LB_N and UB_N always move together
  logic              r_dq_oe;
  logic              r_busy;
  logic [2:0]        r_state_num;

  // Writer wins unless the reader is also asking and the writer went last.
  logic w_grant_wr;
  logic w_grant_rd;
  assign w_grant_wr = bus.wr_req & (~bus.rd_req | r_last_rd);
  assign w_grant_rd = bus.rd_req & ~w_grant_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_rd   <= 1'b1;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_rd_data   <= '0;
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_we_n      <= 1'b1;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_byte_n    <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_busy      <= 1'b0;
      r_state_num <= 3'd0;
    end else begin
      r_wr_ack <= 1'b0;
      r_rd_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_wr) begin
            r_state     <= S_WR_ACC;
            r_last_rd   <= 1'b0;
            r_addr      <= bus.wr_addr;
            r_wr_data   <= bus.wr_data;
            r_ce_n      <= 1'b0;
            r_byte_n    <= 1'b0;
            r_we_n      <= 1'b0;
            r_oe_n      <= 1'b1;
            r_dq_oe     <= 1'b1;
            r_busy      <= 1'b1;
            r_state_num <= 3'd1;
          end else if (w_grant_rd) begin
            r_state     <= S_RD_ACC;
            r_last_rd   <= 1'b1;
            r_addr      <= bus.rd_addr;
            r_ce_n      <= 1'b0;
            r_byte_n    <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b0;
            r_dq_oe     <= 1'b0;
            r_busy      <= 1'b1;
            r_state_num <= 3'd2;
          end
        end
        S_WR_ACC: begin
          if (r_cnt == C_LAST_CNT) begin
            // CE_N and DQ stay active through ACK to give the SRAM hold time
            // after the rising edge of WE_N.
            r_state     <= S_ACK;
            r_we_n      <= 1'b1;
            r_wr_ack    <= 1'b1;
            r_state_num <= 3'd3;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RD_ACC: begin
          if (r_cnt == C_LAST_CNT) begin
            r_state     <= S_ACK;
            r_rd_data   <= sram_dq;
            r_oe_n      <= 1'b1;
            r_ce_n      <= 1'b1;
            r_byte_n    <= 1'b1;
            r_rd_ack    <= 1'b1;
            r_state_num <= 3'd3;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ACK: begin
          r_state     <= S_IDLE;
          r_we_n      <= 1'b1;
          r_ce_n      <= 1'b1;
          r_oe_n      <= 1'b1;
          r_byte_n    <= 1'b1;
          r_dq_oe     <= 1'b0;
          r_busy      <= 1'b0;
          r_state_num <= 3'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sram_dq        = r_dq_oe ? r_wr_data : {DATA_W{1'bz}};
  assign bus.sram_addr  = r_addr;
  assign bus.sram_we_n  = r_we_n;
  assign bus.sram_ce_n  = r_ce_n;
  assign bus.sram_oe_n  = r_oe_n;
  assign bus.sram_lb_n  = r_byte_n;
  assign bus.sram_ub_n  = r_byte_n;
  assign bus.sram_dq_oe = r_dq_oe;
  assign bus.rd_data    = r_rd_data;
  assign bus.wr_ack     = r_wr_ack;
  assign bus.rd_ack     = r_rd_ack;
  assign bus.busy       = r_busy;
  assign bus.state_num  = r_state_num;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_access_arbiter
// Purpose  : Self-checking bench for sram_access_arbiter. A transaction-level
//            reference predicts every output from the grant cycle of the
//            current access; a small SRAM device model answers reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_access_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int AC     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wire [DATA_W-1:0] sram_dq;
  sram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYC(AC)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sram_dq (sram_dq)
  );

  // SRAM device: 32 words, drives DQ while selected for read.
  logic [DATA_W-1:0] sram_mem [0:31];
  wire sram_drive = !bus.sram_ce_n && !bus.sram_oe_n && !bus.sram_dq_oe;
  assign sram_dq = sram_drive ? sram_mem[bus.sram_addr[4:0]] : {DATA_W{1'bz}};
  always @(negedge clk)
    if (!bus.sram_ce_n && !bus.sram_we_n) sram_mem[bus.sram_addr[4:0]] <= sram_dq;

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: one access at a time, described by its grant cycle m_t.
  int                cyc;
  bit                m_act;
  int                m_t;
  bit                m_is_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_sram_addr;
  logic [DATA_W-1:0] m_rd_data;
  bit                m_last_rd;
  logic [DATA_W-1:0] m_mem [0:31];

  task automatic model_reset();
    m_act = 1'b0; m_sram_addr = '0; m_rd_data = '0; m_last_rd = 1'b1;
  endtask

  // Inputs are applied for one cycle, outputs checked at the falling edge,
  // then the reference decides what the rising edge does.
  task automatic run_cycle(input bit r, input bit wr, input logic [ADDR_W-1:0] wa,
                           input logic [DATA_W-1:0] wd, input bit rd,
                           input logic [ADDR_W-1:0] ra);
    int d;
    logic [5:0] e_strb;   // {we_n, oe_n, ce_n, lb_n, ub_n, dq_oe}
    logic [1:0] e_ack;    // {wr_ack, rd_ack}
    logic [3:0] e_bs;     // {busy, state_num}
    rst = r;
    bus.wr_req = wr; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_req = rd; bus.rd_addr = ra;
    d = m_act ? (cyc - m_t) : 1000;
    e_strb = 6'b111110; e_ack = 2'b00; e_bs = 4'd0;
    if (d >= 1 && d <= AC) begin
      e_bs   = m_is_wr ? 4'b1001 : 4'b1010;
      e_strb = m_is_wr ? 6'b010001 : 6'b100000;
    end else if (d == AC + 1) begin
      e_bs = 4'b1011;
      if (m_is_wr) begin
        e_strb = 6'b110001; e_ack = 2'b10;
        m_mem[m_addr[4:0]] = m_data;
      end else begin
        e_strb = 6'b111110; e_ack = 2'b01;
        m_rd_data = m_mem[m_addr[4:0]];
      end
    end
    @(negedge clk);
    check_value("strobes", {58'd0, bus.sram_we_n, bus.sram_oe_n, bus.sram_ce_n,
                            bus.sram_lb_n, bus.sram_ub_n, bus.sram_dq_oe}, {58'd0, e_strb});
    check_value("acks", {62'd0, bus.wr_ack, bus.rd_ack}, {62'd0, e_ack});
    check_value("busy_state", {60'd0, bus.busy, bus.state_num}, {60'd0, e_bs});
    check_value("sram_addr", {44'd0, bus.sram_addr}, {44'd0, m_sram_addr});
    check_value("rd_data", {48'd0, bus.rd_data}, {48'd0, m_rd_data});
    if (e_strb[0]) check_value("dq_write", {48'd0, sram_dq}, {48'd0, m_data});
    if (r) begin
      // An abandoned write has already pulsed WE_N low at least once.
      if (m_act && m_is_wr && d >= 1 && d <= AC) m_mem[m_addr[4:0]] = m_data;
      model_reset();
    end else if (!m_act || d >= AC + 2) begin
      m_act = 1'b0;
      if (wr && (!rd || m_last_rd)) begin
        m_act = 1'b1; m_t = cyc; m_is_wr = 1'b1; m_addr = wa; m_data = wd;
        m_sram_addr = wa; m_last_rd = 1'b0;
      end else if (rd) begin
        m_act = 1'b1; m_t = cyc; m_is_wr = 1'b0; m_addr = ra;
        m_sram_addr = ra; m_last_rd = 1'b1;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      logic [DATA_W-1:0] v;
      v = DATA_W'($urandom);
      sram_mem[i] <= v;
      m_mem[i] = v;
    end
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    run_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);   // reset state
    idle_cycles(2);

    // Single write 0x12 <= 0xBEEF, held until ack.
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 20'h00012, 16'hBEEF, 1'b0, '0);
    idle_cycles(2);

    // Single read of 0x12, held until ack.
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 20'h00012);
    check_value("read_beef", {48'd0, bus.rd_data}, 64'hBEEF);
    idle_cycles(2);

    // Both requesters held high from reset: WR,RD,WR,RD.
    run_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 16; i++)
      run_cycle(1'b0, 1'b1, 20'(5 + i / 4), 16'(16'h1000 + i), 1'b1, 20'(9 + i / 4));
    idle_cycles(2);

    // Reset during the second write-strobe cycle.
    run_cycle(1'b0, 1'b1, 20'h00003, 16'h5A5A, 1'b0, '0);
    run_cycle(1'b0, 1'b1, 20'h00003, 16'h5A5A, 1'b0, '0);
    run_cycle(1'b1, 1'b1, 20'h00003, 16'h5A5A, 1'b0, '0);
    idle_cycles(3);

    // Writer drops req one cycle after being sampled; address changes too.
    run_cycle(1'b0, 1'b1, 20'h00007, 16'hC0DE, 1'b0, '0);
    run_cycle(1'b0, 1'b0, 20'h0001F, 16'h0000, 1'b0, '0);
    idle_cycles(5);

    // Random traffic including protocol violations and occasional resets.
    for (int i = 0; i < 3000; i++)
      run_cycle(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                20'($urandom_range(0, 31)), 16'($urandom),
                1'($urandom_range(0, 1)), 20'($urandom_range(0, 31)));
    idle_cycles(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
